// File: rtl/repetition_scrubber_if.sv
`default_nettype none
// ============================================================================
//  Module      : repetition_scrubber_if
//  Description : Memory port bundle between the repetition scrubber and the
//                shared replicated store (via its request/grant arbiter).
//                master : scrubber side (drives request, write, address, data)
//                slave  : memory/arbiter side (drives grant, read data)
//  Revision    : 1.0 - initial release
// ============================================================================
interface repetition_scrubber_if #(
    parameter int DATA_WIDTH = 8,
    parameter int REPETITION = 3,
    parameter int DEPTH      = 16
);
    localparam int ADDRESS_WIDTH = $clog2(DEPTH);
    localparam int WORD_WIDTH    = REPETITION * DATA_WIDTH;

    logic                     mem_request;
    logic                     mem_grant;
    logic                     mem_write;
    logic [ADDRESS_WIDTH-1:0] mem_address;
    logic [WORD_WIDTH-1:0]    mem_write_data;
    logic [WORD_WIDTH-1:0]    mem_read_data;

    modport master (
        output mem_request,
        output mem_write,
        output mem_address,
        output mem_write_data,
        input  mem_grant,
        input  mem_read_data
    );

    modport slave (
        input  mem_request,
        input  mem_write,
        input  mem_address,
        input  mem_write_data,
        output mem_grant,
        output mem_read_data
    );
endinterface
`default_nettype wire

// File: rtl/repetition_scrubber.sv
`default_nettype none
// ============================================================================
//  Module      : repetition_scrubber
//  Description : Background scrubber for repetition-coded storage. Sweeps all
//                DEPTH words, reads each one, majority-votes the REPETITION
//                copies bit by bit and rewrites the word with every copy set
//                to the voted value whenever any copy disagrees.
//  Ports       : clock            - single rising-edge clock
//                reset            - asynchronous, active-high
//                enable           - scrubbing allowed (checked only in IDLE)
//                mem              - memory port (request/grant handshake)
//                correction_count - words rewritten, saturates at 0xFFFF
//                sweep_done       - one-cycle pulse as the last word completes
//  Revision    : 1.0 - initial release
// ============================================================================
module repetition_scrubber #(
    parameter int DATA_WIDTH = 8,
    parameter int REPETITION = 3,
    parameter int DEPTH      = 16,
    parameter int INTERVAL   = 256
) (
    input  wire logic                 clock,
    input  wire logic                 reset,
    input  wire logic                 enable,
    repetition_scrubber_if.master     mem,
    output logic [15:0]               correction_count,
    output logic                      sweep_done
);

    localparam int ADDRESS_WIDTH = $clog2(DEPTH);
    localparam int WORD_WIDTH    = REPETITION * DATA_WIDTH;
    localparam int TIMER_WIDTH   = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
    localparam int COUNT_WIDTH   = $clog2(REPETITION + 1);

    localparam logic [TIMER_WIDTH-1:0]   LAST_TICK    = TIMER_WIDTH'(INTERVAL - 1);
    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDRESS = ADDRESS_WIDTH'(DEPTH - 1);
    localparam logic [COUNT_WIDTH-1:0]   HALF         = COUNT_WIDTH'(REPETITION / 2);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_WRITE = 3'd4,
        ST_NEXT  = 3'd5
    } state_t;

    state_t                   state_q,   state_d;
    logic [TIMER_WIDTH-1:0]   timer_q,   timer_d;
    logic [ADDRESS_WIDTH-1:0] address_q, address_d;
    logic [WORD_WIDTH-1:0]    buffer_q,  buffer_d;
    logic [DATA_WIDTH-1:0]    vote_q,    vote_d;
    logic [15:0]              count_q,   count_d;

    logic [DATA_WIDTH-1:0]    vote_w;
    logic                     mismatch_w;
    logic [COUNT_WIDTH-1:0]   ones_w;

    // Per-bit majority: strictly more than half the copies must be 1, so an
    // even-REPETITION tie falls to 0.
    always_comb begin
        vote_w = '0;
        ones_w = '0;
        for (int b = 0; b < DATA_WIDTH; b++) begin
            ones_w = '0;
            for (int k = 0; k < REPETITION; k++) begin
                ones_w = ones_w + COUNT_WIDTH'(buffer_q[k*DATA_WIDTH + b]);
            end
            vote_w[b] = (ones_w > HALF);
        end
    end

    always_comb begin
        mismatch_w = 1'b0;
        for (int k = 0; k < REPETITION; k++) begin
            if (buffer_q[k*DATA_WIDTH +: DATA_WIDTH] != vote_w) begin
                mismatch_w = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        address_d = address_q;
        buffer_d  = buffer_q;
        vote_d    = vote_q;
        count_d   = count_q;
        case (state_q)
            ST_IDLE: begin
                if (!enable) begin
                    timer_d = '0;
                end else if (timer_q == LAST_TICK) begin
                    timer_d = '0;
                    state_d = ST_READ;
                end else begin
                    timer_d = timer_q + TIMER_WIDTH'(1);
                end
            end
            ST_READ: begin
                if (mem.mem_grant) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Read data is valid exactly in the cycle after acceptance.
                buffer_d = mem.mem_read_data;
                state_d  = ST_CHECK;
            end
            ST_CHECK: begin
                vote_d  = vote_w;
                state_d = mismatch_w ? ST_WRITE : ST_NEXT;
            end
            ST_WRITE: begin
                if (mem.mem_grant) begin
                    if (count_q != 16'hFFFF) begin
                        count_d = count_q + 16'd1;
                    end
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                address_d = (address_q == LAST_ADDRESS) ? '0
                                                        : address_q + ADDRESS_WIDTH'(1);
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            address_q <= '0;
            buffer_q  <= '0;
            vote_q    <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            address_q <= address_d;
            buffer_q  <= buffer_d;
            vote_q    <= vote_d;
            count_q   <= count_d;
        end
    end

    // Outputs decode only registered state, so request/address/data stay
    // frozen for as long as the arbiter withholds the grant.
    assign mem.mem_request    = (state_q == ST_READ) || (state_q == ST_WRITE);
    assign mem.mem_write      = (state_q == ST_WRITE);
    assign mem.mem_address    = address_q;
    assign mem.mem_write_data = (state_q == ST_WRITE) ? {REPETITION{vote_q}} : '0;
    assign correction_count   = count_q;
    assign sweep_done         = (state_q == ST_NEXT) && (address_q == LAST_ADDRESS);

endmodule
`default_nettype wire

// File: doc/repetition_scrubber.md
# repetition_scrubber

Background scrubber for repetition-coded storage. Sweeps an external memory holding `REPETITION` replicated copies per word, reads each word, majority-votes the copies, and rewrites the word with all copies equal to the voted value when any copy disagrees. It sits downstream of a replicated store and shares the store's port with functional traffic through a request/grant arbiter. This prevents single-copy upsets from accumulating into uncorrectable majorities.

## Interface
- `DATA_WIDTH`, 8: width of one copy.
- `REPETITION`, 3: number of copies per word; must be ≥ 2.
- `DEPTH`, 16: number of words swept; must be ≥ 2.
- `INTERVAL`, 256: idle cycles between scrub steps; must be ≥ 1.
- `ADDRESS_WIDTH`, `$clog2(DEPTH)`: derived, not overridden.
- `clock` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `enable` in 1: scrubbing allowed.
- `mem_request` out 1: scrubber requests the memory port.
- `mem_grant` in 1: access accepted in a cycle where `mem_request` and `mem_grant` are both high.
- `mem_write` out 1: 1 = write access, 0 = read access.
- `mem_address` out `ADDRESS_WIDTH`: word address.
- `mem_write_data` out `REPETITION*DATA_WIDTH`: replicated corrected word.
- `mem_read_data` in `REPETITION*DATA_WIDTH`: valid exactly one cycle after an accepted read.
- `correction_count` out 16: number of words rewritten; saturates at 0xFFFF.
- `sweep_done` out 1: one-cycle pulse when the last address completes.

## Operation
- Word layout: copy k occupies bits `[k*DATA_WIDTH +: DATA_WIDTH]`.
- Vote per bit: 1 if the count of ones across copies is greater than `REPETITION/2` (integer division), else 0. With even `REPETITION`, a tie resolves to 0.
- A mismatch exists when any copy differs from the voted value.
- States:
  - IDLE: timer counts up while `enable` is high. When `enable` is low, the timer is held at 0. When the timer reaches `INTERVAL-1` with `enable` high, clear the timer and go to READ.
  - READ: `mem_request`=1, `mem_write`=0. Hold `mem_address` until grant. Go to WAIT on grant.
  - WAIT: capture `mem_read_data` into an internal buffer. Go to CHECK.
  - CHECK: vote on the buffer. On mismatch go to WRITE, otherwise go to NEXT.
  - WRITE: `mem_request`=1, `mem_write`=1. `mem_write_data` is the voted value replicated `REPETITION` times. On grant, increment `correction_count` (saturating) and go to NEXT.
  - NEXT: if address = `DEPTH-1`, wrap to 0 and pulse `sweep_done`; otherwise increment the address. Go to IDLE.
- Deasserting `enable` outside IDLE does not abort. The current word completes, including any write, and the FSM then waits in IDLE.
- A request, once raised, stays high with address, write and data stable until granted. It is never withdrawn.
- `mem_write_data` is 0 whenever `mem_write` is 0.
- `mem_address` always shows the current word address, including in IDLE.

## Timing
- Reset values: state IDLE, timer 0, address 0. `mem_request`, `mem_write`, `mem_write_data`, `correction_count` and `sweep_done` are all 0.
- All outputs are registered or decoded from state and registers only, with no combinational path from inputs.
- Clean word with immediate grant: READ, WAIT, CHECK, NEXT take 4 cycles, then `INTERVAL` IDLE cycles.
- Corrected word with immediate grants: 5 cycles plus `INTERVAL` IDLE cycles.
- Each cycle of grant stall adds one cycle in READ or WRITE.
- `sweep_done` is high during the NEXT cycle for address `DEPTH-1`. It coincides with the address wrapping to 0 on the following edge.
- `correction_count` updates on the edge that accepts the write.
- Asserting `reset` mid-operation immediately returns all state to reset values. A pending request is dropped.

## Test plan
- Reset, then `enable`=1, grant always high, all memory words clean (copies equal): reads are issued to addresses 0..15 with exactly `INTERVAL` idle cycles between them, no writes occur, `sweep_done` pulses once per 16 words, and `correction_count` stays 0.
- Word 5 = {0xA5, 0xA5, 0xA4} (REPETITION=3): a write to address 5 carries {0xA5, 0xA5, 0xA5} and `correction_count` becomes 1. A second sweep produces no write.
- Grant held low for 7 cycles during READ, then during WRITE: request, address and data stay stable throughout, and the word completes 14 cycles late.
- `enable` dropped during WAIT of a mismatching word: the write still completes, the FSM then stays in IDLE with the timer at 0, and after re-enable the next read occurs after exactly `INTERVAL` cycles.
- REPETITION=2, word = {0x0F, 0xF0}: the write carries {0x00, 0x00} (ties resolve to 0).
- `reset` pulsed while in WRITE with grant low: all outputs go to 0 asynchronously. After release the next read targets address 0. Separately, `correction_count` preloaded by 65535 corrections stays at 0xFFFF after a further correction.
